// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the IMEM loader (IMEM_LOADER_CKSUM_EN adds the CKSUM state)
package imem_pkg;

    localparam int          IMEM_DEPTH_BYTES = 40;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef logic [1:0] lane_t;

`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_FLUSH, ST_CKSUM, ST_DONE, ST_ERR
    } load_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE, ST_ERR
    } load_state_t;
`endif

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - little-endian byte-to-word packer with zero-filled flush and word-valid pulse
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  lane_t       lane,
    input  logic [7:0]  byte_data,
    input  logic        flush,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [31:0] pack;
    logic [31:0] merged;

    always_comb begin
        merged = pack;
        merged[{lane, 3'b000} +: 8] = byte_data;
    end

    // pack restarts from zero after each emitted word, so a flushed partial word has zero upper lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            pack       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                pack <= '0;
            end else if (byte_en) begin
                if (lane == 2'd3 || flush) begin
                    word       <= merged;
                    word_valid <= 1'b1;
                    pack       <= '0;
                end else begin
                    pack <= merged;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream IMEM image loader holding the core in reset during load (IMEM_LOADER_CKSUM_EN adds a trailing checksum byte and cksum port)
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = IMEM_DEPTH_BYTES,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
`ifdef IMEM_LOADER_CKSUM_EN
    ,
    output logic [7:0]        cksum
`endif
);

`ifdef IMEM_LOADER_CKSUM_EN
    localparam load_state_t AFTER_IMAGE = ST_CKSUM;
`else
    localparam load_state_t AFTER_IMAGE = ST_DONE;
`endif

    load_state_t       state, state_nx;
    logic [ADDR_W-1:0] addr;
    lane_t             lane;
    logic              accept;
    logic              data_acc;
    logic              start_load;
    logic              ready_nx;

    assign lane   = addr[1:0];
    assign accept = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        data_acc   = 1'b0;
        start_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nx   = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // the byte arriving at the capacity boundary is swallowed, never written
                    if (addr == ADDR_W'(DEPTH_BYTES)) begin
                        state_nx = ST_ERR;
                    end else begin
                        data_acc = 1'b1;
                        if (s_last) state_nx = (lane == 2'd3) ? AFTER_IMAGE : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_nx = AFTER_IMAGE;
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (accept) state_nx = (8'(cksum + s_data) == 8'h00) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CKSUM_EN
    assign ready_nx = (state_nx == ST_LOAD) || (state_nx == ST_CKSUM);
`else
    assign ready_nx = (state_nx == ST_LOAD);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            waddr    <= '0;
            s_ready  <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            s_ready <= ready_nx;
            if (start_load) begin
                addr     <= '0;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
            end
            if (data_acc) begin
                addr <= addr + 1'b1;
                if (lane == 2'd3 || s_last) waddr <= {addr[ADDR_W-1:2], 2'b00};
            end
            if (state_nx == ST_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (state_nx == ST_ERR) err <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)             cksum <= '0;
        else if (start_load) cksum <= '0;
        else if (data_acc)   cksum <= cksum + s_data;
    end
`endif

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_load),
        .byte_en    (data_acc),
        .lane       (lane),
        .byte_data  (s_data),
        .flush      (s_last),
        .word_valid (we),
        .word       (wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a byte-image reference model
module tb_imem_loader;

    localparam int DEPTH = 40;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_last;
    logic [7:0]  s_data;
    logic        s_ready, we, cpu_hold, done, err;
    logic [31:0] waddr, wdata;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [63:0] wr_q[$];
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
`ifdef IMEM_LOADER_CKSUM_EN
        ,
        .cksum    (cksum)
`endif
    );

    always @(negedge clk) if (we) wr_q.push_back({waddr, wdata});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic junk);
        start   = 1'b1;
        s_valid = junk;
        s_data  = 8'hEE;
        s_last  = 1'b0;
        tick();
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic send(input bit gaps, output int span);
        int first = -1;
        int cyc   = 0;
        int waited;
        for (int k = 0; k < img.size(); k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                tick();
                cyc++;
            end
            s_valid = 1'b1;
            s_data  = img[k];
            s_last  = (k == img.size() - 1);
            waited  = 0;
            while (!s_ready && waited < 50) begin
                tick();
                cyc++;
                waited++;
            end
            if (waited == 50) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
            if (first < 0) first = cyc;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        span    = cyc - first;
    endtask

    // expected IMEM contents: image split into 4-byte words, zero-padded, truncated at capacity
    task automatic check_image(input string tag);
        int          n     = img.size();
        int          kept  = (n > DEPTH) ? DEPTH : n;
        int          nw    = (kept + 3) / 4;
        bit          ovf   = (n > DEPTH);
        logic [31:0] w;
        repeat (3) tick();
        chk($sformatf("%s.nwr", tag), 64'(wr_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            w = '0;
            for (int b = 0; b < 4; b++)
                if (4*i + b < kept) w = w | (32'(img[4*i + b]) << (8*b));
            chk($sformatf("%s.addr%0d", tag, i), 64'(wr_q[i][63:32]), 64'(4*i));
            chk($sformatf("%s.data%0d", tag, i), 64'(wr_q[i][31:0]), 64'(w));
        end
        chk($sformatf("%s.done", tag),     64'(done),     64'(!ovf));
        chk($sformatf("%s.err", tag),      64'(err),      64'(ovf));
        chk($sformatf("%s.cpu_hold", tag), 64'(cpu_hold), 64'(ovf));
        chk($sformatf("%s.s_ready", tag),  64'(s_ready),  64'd0);
    endtask

    task automatic run_image(input string tag, input bit gaps, input logic junk, output int span);
        wr_q.delete();
        do_start(junk);
        send(gaps, span);
        check_image(tag);
    endtask

    task automatic rand_image(input int n);
        img.delete();
        for (int k = 0; k < n; k++) img.push_back(8'($urandom));
    endtask

    initial begin
        int span;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (2) tick();
        chk("rst.s_ready",  64'(s_ready),  64'd0);
        chk("rst.we",       64'(we),       64'd0);
        chk("rst.waddr",    64'(waddr),    64'd0);
        chk("rst.wdata",    64'(wdata),    64'd0);
        chk("rst.cpu_hold", 64'(cpu_hold), 64'd0);
        chk("rst.done",     64'(done),     64'd0);
        chk("rst.err",      64'(err),      64'd0);
        rst = 1'b0;
        tick();

        // full word; a byte offered alongside start must be ignored
        img = '{8'h93, 8'h97, 8'h17, 8'h00};
        run_image("full", 1'b0, 1'b1, span);
        if (wr_q.size() > 0) chk("full.const", 64'(wr_q[0][31:0]), 64'h0017_9793);

        img = '{8'h93, 8'h97, 8'h17, 8'h00, 8'h23, 8'ha4, 8'hf8, 8'h00,
                8'hb3, 8'h88, 8'h07, 8'h01};
        run_image("b2b", 1'b0, 1'b0, span);
        chk("b2b.span", 64'(span), 64'd12);
        if (wr_q.size() == 3) chk("b2b.const2", 64'(wr_q[2][31:0]), 64'h0107_88b3);

        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hAA};
        run_image("flush", 1'b0, 1'b0, span);
        if (wr_q.size() == 2) chk("flush.const", 64'(wr_q[1]), {32'd4, 32'h0000_00AA});

        // reset in the middle of a load
        wr_q.delete();
        do_start(1'b0);
        s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
        tick();
        s_data = 8'h22;
        tick();
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.s_ready",  64'(s_ready),  64'd0);
        chk("mid.we",       64'(we),       64'd0);
        chk("mid.waddr",    64'(waddr),    64'd0);
        chk("mid.wdata",    64'(wdata),    64'd0);
        chk("mid.cpu_hold", 64'(cpu_hold), 64'd0);
        chk("mid.done",     64'(done),     64'd0);
        chk("mid.err",      64'(err),      64'd0);
        repeat (3) tick();
        chk("mid.nwr", 64'(wr_q.size()), 64'd0);
        img = '{8'h44, 8'h33, 8'h22, 8'h11};
        run_image("after_rst", 1'b0, 1'b0, span);

        for (int t = 0; t < 6; t++) begin
            rand_image($urandom_range(1, DEPTH));
            run_image($sformatf("rnd%0d", t), 1'b1, 1'b0, span);
        end

        rand_image(DEPTH);
        run_image("cap", 1'b1, 1'b0, span);
        rand_image(DEPTH + 1);
        run_image("ovf", 1'b0, 1'b0, span);

        // a fresh load after an error must recover cleanly
        rand_image(7);
        run_image("recover", 1'b1, 1'b0, span);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
